// File: rtl/sram22_bist_ctrl.sv
// March C- BIST initiator for sram22 single-port macros, with first-failure capture.
// Define SRAM22_BIST_WMASK_EN to append the byte-mask element M6 up(wm,r).
module sram22_bist_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 6,
  parameter int WMASK_WIDTH    = 4,
  parameter int FAIL_CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [ADDR_WIDTH-1:0]     fail_addr,
  output logic [2:0]                fail_elem,
  output logic [FAIL_CNT_WIDTH-1:0] fail_cnt,
  output logic                      sram_we,
  output logic [WMASK_WIDTH-1:0]    sram_wmask,
  output logic [ADDR_WIDTH-1:0]     sram_addr,
  output logic [DATA_WIDTH-1:0]     sram_din,
  input  logic [DATA_WIDTH-1:0]     sram_dout
);

  localparam int LANE_W = DATA_WIDTH / WMASK_WIDTH;

  function automatic logic [WMASK_WIDTH-1:0] even_lane_mask();
    logic [WMASK_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < WMASK_WIDTH; i++) m[i] = (i % 2) == 0;
    return m;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] even_lane_data();
    logic [DATA_WIDTH-1:0] d;
    d = '0;
    for (int b = 0; b < DATA_WIDTH; b++) d[b] = ((b / LANE_W) % 2) == 0;
    return d;
  endfunction

  localparam logic [WMASK_WIDTH-1:0] EVEN_MASK = even_lane_mask();
  localparam logic [DATA_WIDTH-1:0]  EVEN_DATA = even_lane_data();

  typedef enum logic [3:0] {IDLE, M0, M1, M2, M3, M4, M5, M6, DRAIN, DONE} state_t;

  state_t                  state, nxt_state, elem_after;
  logic [ADDR_WIDTH-1:0]   addr, nxt_addr;
  logic                    phase, nxt_phase;
  logic                    two_op, down;

  logic                    op_we, op_rd;
  logic [WMASK_WIDTH-1:0]  op_wmask;
  logic [ADDR_WIDTH-1:0]   op_addr;
  logic [DATA_WIDTH-1:0]   op_din, op_exp;

  // Read pipeline: rd_* describe the op on the port now, exp_* the one whose data is on dout.
  logic                    rd_pend, cmp_valid, mismatch;
  logic [DATA_WIDTH-1:0]   rd_exp, exp_data;
  logic [ADDR_WIDTH-1:0]   exp_addr;
  logic [2:0]              exp_elem;

  function automatic logic [2:0] elem_idx(state_t s);
    case (s)
      M1:      return 3'd1;
      M2:      return 3'd2;
      M3:      return 3'd3;
      M4:      return 3'd4;
      M5:      return 3'd5;
      M6:      return 3'd6;
      default: return 3'd0;
    endcase
  endfunction

  assign mismatch = cmp_valid && (sram_dout != exp_data);

  always_comb begin
    two_op = state inside {M1, M2, M3, M4, M6};
    down   = state inside {M3, M4};
    case (state)
      M0:      elem_after = M1;
      M1:      elem_after = M2;
      M2:      elem_after = M3;
      M3:      elem_after = M4;
      M4:      elem_after = M5;
`ifdef SRAM22_BIST_WMASK_EN
      M5:      elem_after = M6;
`else
      M5:      elem_after = DRAIN;
`endif
      default: elem_after = DRAIN;
    endcase

    nxt_state = state;
    nxt_addr  = addr;
    nxt_phase = phase;
    case (state)
      IDLE, DONE: if (start) begin
        nxt_state = M0;
        nxt_addr  = '0;
        nxt_phase = 1'b0;
      end
      DRAIN: nxt_state = DONE;
      M0, M1, M2, M3, M4, M5, M6: begin
        if (two_op && !phase) begin
          nxt_phase = 1'b1;
        end else begin
          nxt_phase = 1'b0;
          if (down ? (addr == '0) : (addr == '1)) begin
            nxt_state = elem_after;
            nxt_addr  = (elem_after inside {M3, M4}) ? '1 : '0;
          end else begin
            nxt_addr = down ? addr - 1'b1 : addr + 1'b1;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Decode the op that will be on the SRAM port next cycle.
  always_comb begin
    op_we    = 1'b0;
    op_rd    = 1'b0;
    op_wmask = '0;
    op_addr  = '0;
    op_din   = '0;
    op_exp   = '0;
    if (nxt_state inside {M0, M1, M2, M3, M4, M5, M6}) op_addr = nxt_addr;
    case (nxt_state)
      M0: begin op_we = 1'b1; op_wmask = '1; end
      M1, M3: begin
        if (!nxt_phase) op_rd = 1'b1;
        else begin op_we = 1'b1; op_wmask = '1; op_din = '1; end
      end
      M2, M4: begin
        if (!nxt_phase) begin op_rd = 1'b1; op_exp = '1; end
        else begin op_we = 1'b1; op_wmask = '1; end
      end
      M5: op_rd = 1'b1;
      M6: begin
        if (!nxt_phase) begin op_we = 1'b1; op_wmask = EVEN_MASK; op_din = '1; end
        else begin op_rd = 1'b1; op_exp = EVEN_DATA; end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= '0;
      phase      <= 1'b0;
      sram_we    <= 1'b0;
      sram_wmask <= '0;
      sram_addr  <= '0;
      sram_din   <= '0;
      rd_pend    <= 1'b0;
      rd_exp     <= '0;
      cmp_valid  <= 1'b0;
      exp_data   <= '0;
      exp_addr   <= '0;
      exp_elem   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_addr  <= '0;
      fail_elem  <= '0;
      fail_cnt   <= '0;
    end else begin
      state      <= nxt_state;
      addr       <= nxt_addr;
      phase      <= nxt_phase;
      sram_we    <= op_we;
      sram_wmask <= op_wmask;
      sram_addr  <= op_addr;
      sram_din   <= op_din;
      rd_pend    <= op_rd;
      rd_exp     <= op_exp;
      cmp_valid  <= rd_pend;
      exp_data   <= rd_exp;
      exp_addr   <= sram_addr;
      exp_elem   <= elem_idx(state);
      busy       <= !(nxt_state inside {IDLE, DONE});
      done       <= nxt_state == DONE;
      if ((state inside {IDLE, DONE}) && start) begin
        pass      <= 1'b0;
        fail_addr <= '0;
        fail_elem <= '0;
        fail_cnt  <= '0;
      end else begin
        if (mismatch) begin
          if (fail_cnt == '0) begin
            fail_addr <= exp_addr;
            fail_elem <= exp_elem;
          end
          if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
        end
        // DRAIN carries the final compare, so fold it into pass here.
        if (state == DRAIN) pass <= (fail_cnt == '0) && !mismatch;
      end
    end
  end

endmodule

// File: tb/tb_sram22_bist_ctrl.sv
// Bench for sram22_bist_ctrl: faulty SRAM model, march-walk reference model, per-cycle compare.
module tb_sram22_bist_ctrl;

  localparam int DW  = 32;
  localparam int AW  = 6;
  localparam int MW  = 4;
  localparam int CW  = 8;
  localparam int N   = 1 << AW;
  localparam int LW  = DW / MW;
  localparam int OPW = 1 + MW + AW + DW;
`ifdef SRAM22_BIST_WMASK_EN
  localparam int NEL      = 7;
  localparam int DONE_CYC = 770;
`else
  localparam int NEL      = 6;
  localparam int DONE_CYC = 642;
`endif

  localparam int K_W0 = 0, K_W1 = 1, K_R0 = 2, K_R1 = 3, K_WM = 4, K_RM = 5;
  localparam int EL_DOWN [7] = '{0, 0, 0, 1, 1, 0, 0};
  localparam int EL_NOP  [7] = '{1, 2, 2, 2, 2, 1, 2};
  localparam int EL_OP0  [7] = '{K_W0, K_R0, K_R1, K_R0, K_R1, K_R0, K_WM};
  localparam int EL_OP1  [7] = '{K_W0, K_W1, K_W0, K_W1, K_W0, K_R0, K_RM};

  logic          clk = 1'b0;
  logic          rst, start;
  logic          busy, done, pass;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;
  logic [CW-1:0] fail_cnt;
  logic          sram_we;
  logic [MW-1:0] sram_wmask;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din, sram_dout;

  sram22_bist_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW), .FAIL_CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_cnt(fail_cnt),
    .sram_we(sram_we), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- SRAM model with stuck-at and mask faults ----------------
  logic [DW-1:0] mem [N];
  logic [DW-1:0] sa1 [N];
  logic [DW-1:0] sa0 [N];
  bit            ign_lane1;

  function automatic logic [DW-1:0] faulty(logic [DW-1:0] v, int a);
    return (v | sa1[a]) & ~sa0[a];
  endfunction

  function automatic logic [DW-1:0] masked_write(logic [DW-1:0] old, logic [DW-1:0] d, logic [MW-1:0] m);
    logic [DW-1:0] r;
    r = old;
    for (int l = 0; l < MW; l++)
      if (m[l] || (l == 1 && ign_lane1)) r[l*LW +: LW] = d[l*LW +: LW];
    return r;
  endfunction

  always @(posedge clk) begin
    if (sram_we) mem[sram_addr] <= masked_write(mem[sram_addr], sram_din, sram_wmask);
    else         sram_dout <= faulty(mem[sram_addr], int'(sram_addr));
  end

  task automatic clear_faults();
    for (int a = 0; a < N; a++) begin sa1[a] = '0; sa0[a] = '0; end
    ign_lane1 = 1'b0;
  endtask

  // ---------------- reference model: walk the march table ----------------
  logic [OPW-1:0] exp_q[$];
  int m_cnt, m_faddr, m_felem;
  bit m_pass;

  task automatic build_model();
    logic [DW-1:0] mm [N];
    logic [DW-1:0] rv, ev;
    logic [AW-1:0] av;
    int a, k;
    exp_q.delete();
    m_cnt = 0; m_faddr = 0; m_felem = 0;
    for (int i = 0; i < N; i++) mm[i] = '0;
    for (int e = 0; e < NEL; e++)
      for (int i = 0; i < N; i++) begin
        a  = (EL_DOWN[e] != 0) ? N - 1 - i : i;
        av = AW'(a);
        for (int o = 0; o < EL_NOP[e]; o++) begin
          k = (o == 0) ? EL_OP0[e] : EL_OP1[e];
          if (k == K_W0 || k == K_W1 || k == K_WM) begin
            ev = (k == K_W0) ? '0 : '1;
            exp_q.push_back({1'b1, (k == K_WM) ? 4'b0101 : 4'b1111, av, ev});
            mm[a] = masked_write(mm[a], ev, (k == K_WM) ? 4'b0101 : 4'b1111);
          end else begin
            ev = (k == K_R0) ? 32'h0 : (k == K_R1) ? 32'hFFFF_FFFF : 32'h00FF_00FF;
            exp_q.push_back({1'b0, 4'b0000, av, 32'h0});
            rv = faulty(mm[a], a);
            if (rv !== ev) begin
              if (m_cnt == 0) begin m_faddr = a; m_felem = e; end
              if (m_cnt < (1 << CW) - 1) m_cnt++;
            end
          end
        end
      end
    m_pass = (m_cnt == 0);
  endtask

  // ---------------- scoreboard ----------------
  int n_checks = 0, n_fail = 0;

  task automatic check(string name, logic [63:0] got, logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  bit chk_active = 1'b0, test_done;
  int cyc, n_ops, done_cyc, busy_cycles;
  logic [OPW-1:0] want_op;

  always @(negedge clk) if (chk_active) begin
    cyc++;
    if (busy) busy_cycles++;
    if (done && done_cyc == 0) done_cyc = cyc;
    if (cyc == 1) begin
      check("pass_cleared", 64'(pass), 64'(0));
      check("fail_cnt_cleared", 64'(fail_cnt), 64'(0));
    end
    if (cyc <= n_ops) begin
      want_op = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      check("busy_run", 64'(busy), 64'(1));
      check("done_run", 64'(done), 64'(0));
      check("sram_op", 64'({sram_we, sram_wmask, sram_addr, sram_din}), 64'(want_op));
    end else if (cyc == n_ops + 1) begin
      check("busy_drain", 64'(busy), 64'(1));
      check("done_drain", 64'(done), 64'(0));
      check("sram_op_drain", 64'({sram_we, sram_wmask, sram_addr, sram_din}), 64'(0));
    end else begin
      check("busy_done", 64'(busy), 64'(0));
      check("done_done", 64'(done), 64'(1));
      check("pass", 64'(pass), 64'(m_pass));
      check("fail_cnt", 64'(fail_cnt), 64'(m_cnt));
      check("fail_addr", 64'(fail_addr), 64'(m_faddr));
      check("fail_elem", 64'(fail_elem), 64'(m_felem));
      check("sram_we_done", 64'(sram_we), 64'(0));
      chk_active = 1'b0;
      test_done  = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_all_zero(string tag);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_pass"}, 64'(pass), 64'(0));
    check({tag, "_fail_cnt"}, 64'(fail_cnt), 64'(0));
    check({tag, "_fail_addr"}, 64'(fail_addr), 64'(0));
    check({tag, "_fail_elem"}, 64'(fail_elem), 64'(0));
    check({tag, "_sram"}, 64'({sram_we, sram_wmask, sram_addr, sram_din}), 64'(0));
  endtask

  task automatic run_test(input int restart_at, input int abort_at);
    build_model();
    n_ops = exp_q.size();
    cyc = 0; done_cyc = 0; busy_cycles = 0; test_done = 1'b0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0; chk_active = 1'b1;
    if (abort_at > 0) begin
      repeat (abort_at) @(negedge clk);
      rst = 1'b1; chk_active = 1'b0;
      @(posedge clk); #1;
      check_all_zero("abort");
      @(negedge clk); rst = 1'b0;
      exp_q.delete();
      return;
    end
    if (restart_at > 0) begin
      repeat (restart_at) @(negedge clk);
      start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
    end
    for (int i = 0; i < 3000 && !test_done; i++) @(posedge clk);
    if (!test_done) begin
      n_checks++; n_fail++;
      $display("FAIL timeout: no completion within 3000 cycles, cyc=%0d", cyc);
      chk_active = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0;
    clear_faults();
    for (int a = 0; a < N; a++) mem[a] = '0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk); rst = 1'b0;

    // clean array
    run_test(0, 0);
    check("clean_done_cycle", 64'(done_cyc), 64'(DONE_CYC));
    check("clean_busy_cycles", 64'(busy_cycles), 64'(DONE_CYC - 1));
    check("clean_pass", 64'(pass), 64'(1));
    repeat (5) @(posedge clk);
    #1 check("idle_we", 64'(sram_we), 64'(0));
    check("done_held", 64'(done), 64'(1));

    // bit 3 of word 0x15 stuck at 1
    sa1[21][3] = 1'b1;
    run_test(0, 0);
    check("sa1_fail_addr", 64'(fail_addr), 64'h15);
    check("sa1_fail_elem", 64'(fail_elem), 64'(1));
    check("sa1_fail_cnt", 64'(fail_cnt), 64'(3));
    check("sa1_pass", 64'(pass), 64'(0));

    // many faulty words: counter saturates
    clear_faults();
    for (int a = 3; a < N; a++) begin sa1[a][0] = 1'b1; sa0[a][1] = 1'b1; end
    run_test(0, 0);
    check("sat_fail_cnt", 64'(fail_cnt), 64'(255));
    check("sat_fail_addr", 64'(fail_addr), 64'(3));
    check("sat_fail_elem", 64'(fail_elem), 64'(1));

    // reset mid-test, then a fresh clean run
    clear_faults();
    sa1[21][3] = 1'b1;
    run_test(0, 200);
    clear_faults();
    run_test(0, 0);
    check("post_abort_pass", 64'(pass), 64'(1));

    // start pulsed while busy is ignored
    run_test(50, 0);
    check("restart_done_cycle", 64'(done_cyc), 64'(DONE_CYC));

    // SRAM ignoring mask lane 1
    clear_faults();
    ign_lane1 = 1'b1;
    run_test(0, 0);
`ifdef SRAM22_BIST_WMASK_EN
    check("wm_fail_elem", 64'(fail_elem), 64'(6));
    check("wm_fail_addr", 64'(fail_addr), 64'(0));
    check("wm_done_cycle", 64'(done_cyc), 64'(770));
`else
    check("wm_pass", 64'(pass), 64'(1));
`endif

    // randomized faults, idle gaps and stray start pulses
    for (int t = 0; t < 8; t++) begin
      int nf, a, b;
      clear_faults();
      nf = $urandom_range(0, 4);
      for (int f = 0; f < nf; f++) begin
        a = $urandom_range(0, N - 1);
        b = $urandom_range(0, DW - 1);
        if ($urandom_range(0, 1) == 1) sa1[a][b] = 1'b1;
        else                           sa0[a][b] = 1'b1;
      end
      ign_lane1 = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 4)) @(posedge clk);
      run_test(($urandom_range(0, 1) == 1) ? $urandom_range(1, 600) : 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
